fport_telemetry_scheduler: RTL and testbench
============================================

Name: fport_telemetry_scheduler

Overview:
- Sequences the F.Port uplink (telemetry response) path after each downlink control frame ends.
- Arbitrates round-robin among NUM_SOURCES telemetry requesters and builds the 9-byte response frame with CRC and byte stuffing.
- Drives the inverted uplink uart through its send/done handshake and owns the half-duplex drive-enable on the fport pin.
- Sits between the fport receiver (slot_open) and the uart transmitter.

Parameters:
- NUM_SOURCES, 4: number of telemetry requesters (2..8).
- GUARD_CLOCKS, 600: clocks between slot_open and first byte (bus turnaround).
- RELEASE_CLOCKS, 104: clocks drive_enable stays high after last byte's done.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- slot_open  in  1  one-cycle pulse: downlink control frame ended, response window begins
- src_valid  in  NUM_SOURCES  requester has a sample
- src_app_id  in  16*NUM_SOURCES  per-source application id, source i at [16i+15:16i]
- src_data  in  32*NUM_SOURCES  per-source value, source i at [32i+31:32i]
- src_ready  out  NUM_SOURCES  one-cycle grant pulse; sample is consumed
- tx_send  out  1  one-cycle start pulse to uart
- tx_byte  out  8  byte to uart, stable from tx_send until the following tx_done rise
- tx_done  in  1  uart idle level (1 = idle)
- drive_enable  out  1  fport output enable (1 = drive pin)
- busy  out  1  not in IDLE
- slots_missed  out  8  saturating count of slot_open pulses ignored while busy

Behaviour:
- Reset values: src_ready=0, tx_send=0, tx_byte=0, drive_enable=0, busy=0, slots_missed=0, rr pointer=0, state=IDLE.
- Reset mid-frame aborts immediately. drive_enable drops on the cycle reset is sampled; no partial byte completion.
- IDLE: on slot_open go to GUARD, load the guard counter with GUARD_CLOCKS-1, and assert drive_enable in the same cycle.
- GUARD: count down to 0, then go to ARB.
- ARB (1 cycle): pick the first valid source at or after the rr pointer, with wrap-around. Grant pulses src_ready[g] for exactly this cycle. Latch app_id/data into the frame register. Pointer becomes (g+1) mod NUM_SOURCES.
- ARB with no source valid: latch an empty frame (prim 0x00, app_id 0, data 0). Pointer is unchanged and no src_ready pulse is issued.
- Frame bytes in order: 0x08, 0x81, prim (0x10 for data, 0x00 for empty), app_id[7:0], app_id[15:8], data[7:0], data[15:8], data[23:16], data[31:24], CRC.
- CRC, 8-bit with carry fold over the 9 bytes from 0x08 through data[31:24]:
  - for each byte: s = s + b; s = s[7:0] + s[8].
  - CRC = 0xFF - s.
  - Computed incrementally as bytes are emitted, before stuffing.
- Stuffing applies to every emitted byte including CRC: 0x7E is sent as 0x7D,0x5E; 0x7D is sent as 0x7D,0x5D.
- SEND: when tx_done=1, present tx_byte and pulse tx_send for one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_done=0, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_done=1. Then send the pending second stuffed byte if any, otherwise advance to the next byte. After the CRC completes, go to RELEASE.
- Never more than one tx_send per uart transaction. tx_send never asserts while tx_done=0.
- RELEASE: hold drive_enable for RELEASE_CLOCKS, then drive_enable=0 and return to IDLE.
- slot_open in any state except IDLE: ignored and slots_missed increments, saturating at 255.
- slot_open in the same cycle RELEASE ends: ignored and counted; the block is still busy that cycle.
- src_valid changing during a frame has no effect. Data is captured only in ARB.

Decomposition:
- Package fport_pkg: frame constants (0x08 length, 0x81 type, 0x10/0x00 prim, 0x7E/0x7D/0x5E/0x5D), state encoding, CRC step function.
- One sub-module, fport_rr_arbiter: combinational grant from valid plus pointer, with a registered pointer update.
- Frame build, CRC, stuffing and uart handshake stay in this module.

Test Plan:
- Data frame: source 0 valid, app_id 0x5100, data 0x00000001, slot_open -> bytes 08 81 10 00 51 01 00 00 00 14; src_ready[0] pulses once; drive_enable high from slot_open until RELEASE_CLOCKS after the last done.
- Empty frame: no sources valid, slot_open -> bytes 08 81 00 00 00 00 00 00 00 76; no src_ready pulse.
- Stuffing: app_id 0x5100, data 0x0000007E -> bytes 08 81 10 00 51 7D 5E 00 00 00 96 (11 uart transactions).
- Round-robin: sources 1 and 3 held valid over 3 slots -> grants go 1, 3, 1.
- Collision and reset: slot_open pulsed mid-frame -> slots_missed=1 and frame unaffected; reset_n low during byte 4 -> drive_enable=0 next cycle, and the next slot_open produces a complete fresh frame.
- Handshake: uart model holding tx_done low for a random 1..2000 clocks -> exactly one tx_send per byte, never while tx_done=0.

Source files
------------

// File: rtl/fport_telemetry_scheduler_pkg.sv
// Shared F.Port uplink constants, state encoding, latched-frame layout and CRC step.
package fport_pkg;

    localparam logic [7:0] FRAME_LEN  = 8'h08;
    localparam logic [7:0] FRAME_TYPE = 8'h81;
    localparam logic [7:0] PRIM_DATA  = 8'h10;
    localparam logic [7:0] PRIM_EMPTY = 8'h00;
    localparam logic [7:0] ESC_FLAG   = 8'h7E;
    localparam logic [7:0] ESC_BYTE   = 8'h7D;
    localparam logic [7:0] XOR_FLAG   = 8'h5E;
    localparam logic [7:0] XOR_BYTE   = 8'h5D;

    // Index of the CRC byte; bytes 0..8 feed the checksum.
    localparam logic [3:0] CRC_IDX = 4'd9;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GUARD     = 3'd1;
    localparam logic [2:0] ST_ARB       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd4;
    localparam logic [2:0] ST_WAIT_DONE = 3'd5;
    localparam logic [2:0] ST_RELEASE   = 3'd6;

    typedef struct packed {
        logic [7:0]  prim;
        logic [15:0] app_id;
        logic [31:0] data;
    } frame_t;

    // 8-bit add with end-around carry.
    function automatic logic [7:0] crc_step(input logic [7:0] s, input logic [7:0] b);
        logic [8:0] t;
        t = {1'b0, s} + {1'b0, b};
        return t[7:0] + {7'd0, t[8]};
    endfunction

endpackage

// File: rtl/fport_telemetry_scheduler_if.sv
// Requester and uart handshake bundle; master is the scheduler side.
interface fport_telemetry_scheduler_if #(parameter int NUM_SOURCES = 4);

    logic [NUM_SOURCES-1:0]    src_valid;
    logic [16*NUM_SOURCES-1:0] src_app_id;
    logic [32*NUM_SOURCES-1:0] src_data;
    logic [NUM_SOURCES-1:0]    src_ready;
    logic                      tx_send;
    logic [7:0]                tx_byte;
    logic                      tx_done;

    modport master (
        input  src_valid, src_app_id, src_data, tx_done,
        output src_ready, tx_send, tx_byte
    );

    modport slave (
        output src_valid, src_app_id, src_data, tx_done,
        input  src_ready, tx_send, tx_byte
    );

endinterface

// File: rtl/fport_telemetry_scheduler_rr_arbiter.sv
// Round-robin pick of the first valid requester at or after the pointer.
module fport_rr_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int PW          = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_SOURCES-1:0] valid,
    input  logic                   update,
    output logic [NUM_SOURCES-1:0] grant,
    output logic [PW-1:0]          gnt_idx,
    output logic                   gnt_any
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   s;

    // Scan from the far end so the closest valid source to the pointer wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        s       = '0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            s = {1'b0, ptr_q} + (PW+1)'(k);
            if (s >= (PW+1)'(NUM_SOURCES)) s = s - (PW+1)'(NUM_SOURCES);
            if (valid[s[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = s[PW-1:0];
            end
        end
        grant = gnt_any ? (NUM_SOURCES'(1) << gnt_idx) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update && gnt_any)
            ptr_d = (gnt_idx == PW'(NUM_SOURCES - 1)) ? '0 : gnt_idx + PW'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fport_telemetry_scheduler.sv
// F.Port uplink slot sequencer: guard, arbitrate, send stuffed CRC frame, release the pin.
module fport_telemetry_scheduler
    import fport_pkg::*;
#(
    parameter int NUM_SOURCES    = 4,
    parameter int GUARD_CLOCKS   = 600,
    parameter int RELEASE_CLOCKS = 104
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                slot_open,
    fport_telemetry_scheduler_if.master         bus,
    output logic                                drive_enable,
    output logic                                busy,
    output logic [7:0]                          slots_missed
);

    localparam int PW   = $clog2(NUM_SOURCES);
    localparam int CMAX = (GUARD_CLOCKS > RELEASE_CLOCKS) ? GUARD_CLOCKS : RELEASE_CLOCKS;
    localparam int CW   = $clog2(CMAX + 1);

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic           stuff_q, stuff_d;
    logic [7:0]     crc_q, crc_d;
    frame_t         frame_q, frame_d;
    logic           tx_send_q, tx_send_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic           drive_q, drive_d;
    logic [7:0]     missed_q, missed_d;

    logic [NUM_SOURCES-1:0] grant;
    logic [PW-1:0]          gnt_idx;
    logic                   gnt_any;
    logic [7:0]             cur_byte, out_byte;
    logic                   cur_esc;

    fport_rr_arbiter #(.NUM_SOURCES(NUM_SOURCES), .PW(PW)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .valid   (bus.src_valid),
        .update  (state_q == ST_ARB),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        case (idx_q)
            4'd0:    cur_byte = FRAME_LEN;
            4'd1:    cur_byte = FRAME_TYPE;
            4'd2:    cur_byte = frame_q.prim;
            4'd3:    cur_byte = frame_q.app_id[7:0];
            4'd4:    cur_byte = frame_q.app_id[15:8];
            4'd5:    cur_byte = frame_q.data[7:0];
            4'd6:    cur_byte = frame_q.data[15:8];
            4'd7:    cur_byte = frame_q.data[23:16];
            4'd8:    cur_byte = frame_q.data[31:24];
            default: cur_byte = 8'hFF - crc_q;
        endcase
        cur_esc = (cur_byte == ESC_FLAG) || (cur_byte == ESC_BYTE);
        // stuff_q marks that the escape lead-in already went out for cur_byte.
        if (stuff_q)      out_byte = (cur_byte == ESC_FLAG) ? XOR_FLAG : XOR_BYTE;
        else if (cur_esc) out_byte = ESC_BYTE;
        else              out_byte = cur_byte;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        stuff_d   = stuff_q;
        crc_d     = crc_q;
        frame_d   = frame_q;
        tx_send_d = 1'b0;
        tx_byte_d = tx_byte_q;
        drive_d   = drive_q;
        missed_d  = missed_q;

        if (slot_open && state_q != ST_IDLE && missed_q != 8'hFF)
            missed_d = missed_q + 8'd1;

        case (state_q)
            ST_IDLE: if (slot_open) begin
                state_d = ST_GUARD;
                cnt_d   = CW'(GUARD_CLOCKS - 1);
                drive_d = 1'b1;
            end
            ST_GUARD: begin
                if (cnt_q == '0) state_d = ST_ARB;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_ARB: begin
                if (gnt_any)
                    frame_d = '{prim:   PRIM_DATA,
                                app_id: bus.src_app_id[int'(gnt_idx)*16 +: 16],
                                data:   bus.src_data[int'(gnt_idx)*32 +: 32]};
                else
                    frame_d = '{prim: PRIM_EMPTY, app_id: 16'h0, data: 32'h0};
                idx_d   = 4'd0;
                stuff_d = 1'b0;
                crc_d   = 8'h00;
                state_d = ST_SEND;
            end
            ST_SEND: if (bus.tx_done) begin
                tx_send_d = 1'b1;
                tx_byte_d = out_byte;
                state_d   = ST_WAIT_BUSY;
                if (stuff_q) begin
                    stuff_d = 1'b0;
                end else begin
                    if (idx_q != CRC_IDX) crc_d = crc_step(crc_q, cur_byte);
                    stuff_d = cur_esc;
                end
            end
            ST_WAIT_BUSY: if (!bus.tx_done) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.tx_done) begin
                if (stuff_q) begin
                    state_d = ST_SEND;
                end else if (idx_q == CRC_IDX) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CW'(RELEASE_CLOCKS - 1);
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_SEND;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    drive_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                drive_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            stuff_q   <= 1'b0;
            crc_q     <= '0;
            frame_q   <= '0;
            tx_send_q <= 1'b0;
            tx_byte_q <= '0;
            drive_q   <= 1'b0;
            missed_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stuff_q   <= stuff_d;
            crc_q     <= crc_d;
            frame_q   <= frame_d;
            tx_send_q <= tx_send_d;
            tx_byte_q <= tx_byte_d;
            drive_q   <= drive_d;
            missed_q  <= missed_d;
        end
    end

    assign bus.src_ready  = grant & {NUM_SOURCES{state_q == ST_ARB}};
    assign bus.tx_send    = tx_send_q;
    assign bus.tx_byte    = tx_byte_q;
    assign drive_enable   = drive_q;
    assign busy           = (state_q != ST_IDLE);
    assign slots_missed   = missed_q;

endmodule

// File: tb/tb_fport_telemetry_scheduler.sv
// Randomized scoreboard bench: a frame-level reference model queues bytes/grants, a monitor pops them.
module tb_fport_telemetry_scheduler;

    localparam int NS = 4;
    localparam int GC = 600;
    localparam int RC = 104;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       slot_open = 1'b0;
    logic       drive_enable, busy;
    logic [7:0] slots_missed;

    fport_telemetry_scheduler_if #(.NUM_SOURCES(NS)) bus();

    fport_telemetry_scheduler #(.NUM_SOURCES(NS), .GUARD_CLOCKS(GC), .RELEASE_CLOCKS(RC)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .slot_open    (slot_open),
        .bus          (bus),
        .drive_enable (drive_enable),
        .busy         (busy),
        .slots_missed (slots_missed)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;
    int cyc = 0, done_cyc = 0, slot_cyc = 0, first_cyc = -1, sent = 0;
    int uart_max = 20;
    int rr_m = 0, miss_m = 0;
    logic [7:0]  exp_q[$];
    int          exp_g[$];
    logic [15:0] app_m[NS];
    logic [31:0] dat_m[NS];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // UART: drops done one cycle after seeing send, stays busy a random time.
    initial begin
        int d;
        bus.tx_done = 1'b1;
        forever begin
            @(posedge clock);
            if (reset_n && bus.tx_send === 1'b1) begin
                d = $urandom_range(uart_max, 1);
                #1 bus.tx_done = 1'b0;
                repeat (d) @(posedge clock);
                #1 bus.tx_done = 1'b1;
                done_cyc = cyc;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.src_ready != '0) begin
                if (exp_g.size() == 0) check("grant_extra", exp_g.size(), 1);
                else check("grant", 32'(bus.src_ready), 32'(1) << exp_g.pop_front());
            end
            if (bus.tx_send) begin
                check("send_while_busy", 32'(bus.tx_done), 1);
                if (first_cyc < 0) first_cyc = cyc;
                sent++;
                if (exp_q.size() == 0) check("byte_extra", exp_q.size(), 1);
                else check("tx_byte", 32'(bus.tx_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_stuffed(input logic [7:0] b);
        if (b == 8'h7E) begin exp_q.push_back(8'h7D); exp_q.push_back(8'h5E); end
        else if (b == 8'h7D) begin exp_q.push_back(8'h7D); exp_q.push_back(8'h5D); end
        else exp_q.push_back(b);
    endtask

    // Frame-level reference: choose the source, build bytes, checksum, stuff.
    task automatic model_slot(input logic [NS-1:0] v);
        int g = -1;
        int s = 0;
        logic [15:0] app = 16'h0;
        logic [31:0] dat = 32'h0;
        logic [7:0]  raw[9];
        for (int k = 0; k < NS; k++)
            if (g < 0 && v[(rr_m + k) % NS]) g = (rr_m + k) % NS;
        if (g >= 0) begin
            exp_g.push_back(g);
            app = app_m[g];
            dat = dat_m[g];
            rr_m = (g + 1) % NS;
        end
        raw = '{8'h08, 8'h81, (g >= 0) ? 8'h10 : 8'h00, app[7:0], app[15:8],
                dat[7:0], dat[15:8], dat[23:16], dat[31:24]};
        for (int i = 0; i < 9; i++) begin
            s = s + raw[i];
            if (s > 255) s = s - 255;
            push_stuffed(raw[i]);
        end
        push_stuffed(8'(255 - s));
    endtask

    task automatic drive_src(input logic [NS-1:0] v);
        bus.src_valid = v;
        for (int i = 0; i < NS; i++) begin
            bus.src_app_id[16*i +: 16] = app_m[i];
            bus.src_data[32*i +: 32]   = dat_m[i];
        end
    endtask

    task automatic start_slot();
        int n = 0;
        while (!bus.tx_done && n < 5000) begin tick(); n++; end
        check("uart_idle_before_slot", 32'(bus.tx_done), 1);
        first_cyc = -1;
        sent = 0;
        model_slot(bus.src_valid);
        slot_open = 1'b1;
        tick();
        slot_open = 1'b0;
        slot_cyc = cyc;
        check("drive_en_on", 32'(drive_enable), 1);
        check("busy_on", 32'(busy), 1);
    endtask

    task automatic finish_frame();
        int n = 0;
        while (busy && n < 80000) begin tick(); n++; end
        check("frame_done", 32'(busy), 0);
        check("drive_en_off", 32'(drive_enable), 0);
        // done seen high on the next edge, then RC clocks of hold.
        check("release_len", cyc - done_cyc, RC + 1);
        check("guard_len", ((first_cyc - slot_cyc) >= GC) && ((first_cyc - slot_cyc) <= GC + 3), 1);
        check("bytes_left", exp_q.size(), 0);
        check("grants_left", exp_g.size(), 0);
        check("slots_missed", 32'(slots_missed), miss_m);
    endtask

    task automatic set_src(input int i, input logic [15:0] a, input logic [31:0] d);
        app_m[i] = a;
        dat_m[i] = d;
    endtask

    initial begin
        int n;
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) set_src(i, 16'($urandom), $urandom);
        drive_src('0);
        repeat (3) tick();
        check("rst_src_ready", 32'(bus.src_ready), 0);
        check("rst_tx_send", 32'(bus.tx_send), 0);
        check("rst_tx_byte", 32'(bus.tx_byte), 0);
        check("rst_drive_en", 32'(drive_enable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_missed", 32'(slots_missed), 0);
        reset_n = 1'b1;
        tick();

        // Data frame, empty frame, stuffed data byte.
        set_src(0, 16'h5100, 32'h0000_0001);
        drive_src(4'b0001); start_slot(); finish_frame();
        drive_src(4'b0000); start_slot(); finish_frame();
        set_src(0, 16'h5100, 32'h0000_007E);
        drive_src(4'b0001); start_slot(); finish_frame();

        // Round robin across sources 1 and 3.
        drive_src(4'b1010);
        repeat (3) begin start_slot(); finish_frame(); end

        // Collision mid-frame, then the requester changes after its grant.
        set_src(2, 16'h7D7E, 32'h7E7D_1234);
        drive_src(4'b0100);
        start_slot();
        repeat (50) tick();
        slot_open = 1'b1; tick(); slot_open = 1'b0;
        miss_m++;
        n = 0;
        while (sent < 1 && n < 5000) begin tick(); n++; end
        set_src(2, 16'hFFFF, 32'hDEAD_BEEF);
        drive_src(4'b1111);
        finish_frame();

        // Reset while the fourth byte is in flight.
        set_src(0, 16'h5100, 32'h0000_0001);
        drive_src(4'b0001);
        start_slot();
        n = 0;
        while (sent < 4 && n < 20000) begin tick(); n++; end
        check("reset_point_reached", 32'(sent >= 4), 1);
        reset_n = 1'b0;
        tick();
        check("abort_drive_en", 32'(drive_enable), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_tx_send", 32'(bus.tx_send), 0);
        check("abort_missed", 32'(slots_missed), 0);
        exp_q.delete();
        exp_g.delete();
        rr_m = 0;
        miss_m = 0;
        reset_n = 1'b1;
        tick();
        start_slot(); finish_frame();

        // Long uart busy periods.
        uart_max = 2000;
        set_src(3, 16'($urandom), $urandom);
        drive_src(4'b1000); start_slot(); finish_frame();
        uart_max = 20;

        // Random requesters with escape bytes sprinkled in.
        repeat (5) begin
            for (int i = 0; i < NS; i++)
                set_src(i, {($urandom_range(1) ? 8'h7E : 8'($urandom)), 8'($urandom)},
                        {8'($urandom), ($urandom_range(1) ? 8'h7D : 8'($urandom)), 16'($urandom)});
            v = NS'($urandom);
            drive_src(v);
            start_slot();
            finish_frame();
        end

        // Many ignored slots during guard saturate the counter.
        drive_src(4'b0010);
        start_slot();
        repeat (260) begin
            slot_open = 1'b1; tick(); slot_open = 1'b0; tick();
        end
        miss_m = (miss_m + 260 > 255) ? 255 : miss_m + 260;
        finish_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
